jk_drive_sequencer: RTL and testbench
=====================================

# jk_drive_sequencer

Command-driven stimulus stage that sits directly upstream of the JK flip-flop and drives its `j`/`k` inputs. It accepts opcode/repeat-count commands through a valid/ready handshake into a small FIFO. It applies each command to the flip-flop for a programmed number of clock cycles. It then checks the flip-flop's `q` against the expected result and reports completion and any mismatch.

## Interface
- `CNT_W`, 4: width of the repeat-count field.
- `FIFO_DEPTH`, 4: command FIFO entries; must be a power of 2 and at least 2.
- `clk`  in  1  rising-edge clock, shared with the downstream JK flip-flop.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  FIFO can accept a command (`!full`).
- `cmd_op`  in  2  opcode: 00 HOLD (j=0,k=0), 01 RESET (0,1), 10 SET (1,0), 11 TOGGLE (1,1).
- `cmd_cnt`  in  CNT_W  repeat count; the command is applied for `cmd_cnt+1` cycles.
- `err_clr`  in  1  clears the sticky `err` flag.
- `q`  in  1  flip-flop output fed back for checking.
- `j`, `k`  out  1 each  registered drive to the flip-flop.
- `busy`  out  1  high when not IDLE or the FIFO is non-empty.
- `done`  out  1  one-cycle pulse per completed command.
- `err`  out  1  sticky mismatch flag.

## Operation
- Push: a command is written when `cmd_valid && cmd_ready`. `cmd_ready` depends only on the registered full state, so a pop in the same cycle does not enable a push into a full FIFO.
- There is no bypass path. A command pushed into an empty FIFO is popped no earlier than the next cycle.
- IDLE:
  - `j=k=0`.
  - If the FIFO is non-empty: pop the command, load `op`, load `cnt`, capture `q_start=q`, and go to DRIVE.
- DRIVE:
  - `j`/`k` are driven per `op` on every DRIVE cycle.
  - When `cnt==0`, go to CHECK. Otherwise decrement `cnt`.
- CHECK (1 cycle):
  - `j=k=0` and `done=1`.
  - Compare `q` with `q_exp`:
    - HOLD: `q_start`.
    - RESET: 0.
    - SET: 1.
    - TOGGLE: `q_start ^ ((cnt_orig+1)&1)`.
  - On mismatch, `err<=1`. Then go to IDLE.
- Counter arithmetic is CNT_W-bit unsigned; there is no wrap, because the decrement stops at 0.
- `err` is sticky and cleared by `err_clr`. If `err_clr` and a mismatch occur in the same cycle, the set wins.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full/empty are decided by the MSB-difference rule.

## Timing
- Reset values: `j=0`, `k=0`, `cmd_ready=0` while `rst_n` is low and 1 from the first cycle after release, `busy=0`, `done=0`, `err=0`, state IDLE, FIFO empty.
- Reset mid-operation aborts the current command, flushes the FIFO, and forces `j=k=0` immediately (asynchronous).
- Latency from pop (IDLE cycle) to first `j`/`k` drive: 1 cycle.
- A command occupies `cmd_cnt+3` cycles: IDLE + (`cmd_cnt+1`) DRIVE + CHECK.
- The flip-flop samples its last driven `j`/`k` on the edge entering CHECK, so `q` is valid during CHECK.
- `done` and the `err` update both occur in the CHECK cycle. `err` is visible on the following cycle.

## Configuration
- `JKSEQ_CHECK_EN` defined: `q_start` capture, expected-value logic, and the `err`/`err_clr` behaviour are compiled in as described above.
- `JKSEQ_CHECK_EN` undefined: no checker logic. `err` is tied to 0, `err_clr` and `q` are ignored, and `done` and the CHECK state are unchanged.

## Test plan
- Reset: hold `rst_n=0` mid-DRIVE of a SET with cnt=5 → `j=k=0` immediately, `busy=0`, `err=0`. After release, `cmd_ready=1` and the FIFO is empty.
- Single SET, cnt=0, starting with q=0 → `j=1,k=0` for exactly 1 cycle, `done` 2 cycles later, `q=1`, `err=0`.
- TOGGLE cnt=2 (3 cycles) from q=0 → `q=1` at CHECK, no error. TOGGLE cnt=1 from q=1 → `q=1`, no error.
- Back-pressure: push 5 commands back-to-back with FIFO_DEPTH=4 → `cmd_ready=0` after 4 pushes. The 5th is accepted only after the first pop, and execution order is preserved.
- Mismatch: force `q` stuck at 0 and issue SET cnt=0 → `err=1` after CHECK. `err_clr` pulse → `err=0`. `err_clr` coincident with a new mismatch → `err` stays 1.
- Macro off: the same stuck-q SET → `done` pulses and `err` stays 0.

Source files
------------

// File: rtl/jk_drive_sequencer.sv
// Command FIFO + drive sequencer for an external JK flip-flop: applies j/k per opcode for cnt+1 cycles, then checks q.
// Optional checker (q_start capture, expected value, sticky err) compiled in with `define JKSEQ_CHECK_EN.
module jk_drive_sequencer #(
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             err_clr,
    input  logic             q,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [1:0]       op;
        logic [CNT_W-1:0] cnt;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK} state_t;

    cmd_t             mem [FIFO_DEPTH];
    cmd_t             head;
    logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic             empty, empty_n, full_n, push, pop;
    state_t           state, state_n;
    logic [1:0]       op, op_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             j_n, k_n, done_n, busy_n;

    // FIFO bookkeeping; ready follows the registered full state only
    assign head     = mem[rd_ptr[AW-1:0]];
    assign empty    = (wr_ptr == rd_ptr);
    assign push     = cmd_valid && cmd_ready;
    assign pop      = (state == S_IDLE) && !empty;
    assign wr_ptr_n = wr_ptr + (AW+1)'(push);
    assign rd_ptr_n = rd_ptr + (AW+1)'(pop);
    assign empty_n  = (wr_ptr_n == rd_ptr_n);
    assign full_n   = (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                      (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= cmd_t'{op: cmd_op, cnt: cmd_cnt};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state plus next values of the registered outputs
    always_comb begin
        state_n = state;
        op_n    = op;
        cnt_n   = cnt;
        j_n     = 1'b0;
        k_n     = 1'b0;
        done_n  = 1'b0;
        busy_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    state_n = S_DRIVE;
                    op_n    = head.op;
                    cnt_n   = head.cnt;
                end
            end
            S_DRIVE: begin
                if (cnt == '0) state_n = S_CHECK;
                else           cnt_n   = cnt - CNT_W'(1);
            end
            S_CHECK: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        j_n    = (state_n == S_DRIVE) && op_n[1];
        k_n    = (state_n == S_DRIVE) && op_n[0];
        done_n = (state_n == S_CHECK);
        busy_n = (state_n != S_IDLE) || !empty_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            op        <= 2'b00;
            cnt       <= '0;
            cmd_ready <= 1'b0;
            j         <= 1'b0;
            k         <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            op        <= op_n;
            cnt       <= cnt_n;
            cmd_ready <= !full_n;
            j         <= j_n;
            k         <= k_n;
            done      <= done_n;
            busy      <= busy_n;
        end
    end

`ifdef JKSEQ_CHECK_EN
    logic q_start, cnt_lsb, q_exp, mismatch;

    // TOGGLE runs cnt+1 cycles, so q flips iff the original count is even
    always_comb begin
        q_exp = q_start;
        case (op)
            2'b00: q_exp = q_start;
            2'b01: q_exp = 1'b0;
            2'b10: q_exp = 1'b1;
            2'b11: q_exp = q_start ^ ~cnt_lsb;
            default: q_exp = q_start;
        endcase
    end

    assign mismatch = (state == S_CHECK) && (q != q_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_start <= 1'b0;
            cnt_lsb <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (pop) begin
                q_start <= q;
                cnt_lsb <= head.cnt[0];
            end
            if (mismatch)     err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end
`else
    logic unused_chk;
    assign unused_chk = ^{q, err_clr};
    assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Directed self-checking bench for jk_drive_sequencer with a behavioural JK flip-flop on q.
// Expected err behaviour follows whether JKSEQ_CHECK_EN is defined for the build.
module tb_jk_drive_sequencer;
`ifdef JKSEQ_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, cmd_valid, cmd_ready, err_clr, q, j, k, busy, done, err;
    logic [1:0] cmd_op;
    logic [3:0] cmd_cnt;

    logic       q_ff, q_load, q_load_val, stuck;
    logic [5:0] run_len;
    logic [1:0] last_jk;
    logic [7:0] log_q [$];

    int checks = 0;
    int errors = 0;

    jk_drive_sequencer #(.CNT_W(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .err_clr(err_clr), .q(q),
        .j(j), .k(k), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Downstream JK flip-flop, with a stuck-at-0 fault injector on q
    always @(posedge clk) begin
        if (q_load) q_ff <= q_load_val;
        else begin
            case ({j, k})
                2'b01: q_ff <= 1'b0;
                2'b10: q_ff <= 1'b1;
                2'b11: q_ff <= ~q_ff;
                default: q_ff <= q_ff;
            endcase
        end
    end
    assign q = stuck ? 1'b0 : q_ff;

    // Log one {jk, drive length} entry per done pulse
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len <= 6'd0;
            last_jk <= 2'b00;
        end else if (done) begin
            log_q.push_back({last_jk, run_len});
            run_len <= 6'd0;
            last_jk <= 2'b00;
        end else if (j || k) begin
            run_len <= run_len + 6'd1;
            last_jk <= {j, k};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_q(input logic v);
        q_load = 1'b1;
        q_load_val = v;
        step();
        q_load = 1'b0;
    endtask

    task automatic push(input logic [1:0] o, input logic [3:0] c);
        bit ok = 1'b0;
        cmd_op = o;
        cmd_cnt = c;
        cmd_valid = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (cmd_ready) ok = 1'b1;
            step();
            if (ok) break;
        end
        cmd_valid = 1'b0;
        chk("push_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(output int n_drive);
        bit seen = 1'b0;
        n_drive = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (j || k) n_drive++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int n;
        int base;
        logic [7:0] exp_log [6];
        exp_log = '{8'hD0, 8'h81, 8'h42, 8'hC3, 8'h81, 8'h42};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_cnt = 4'd0;
        err_clr = 1'b0; q_load = 1'b0; q_load_val = 1'b0; stuck = 1'b0;
        set_q(1'b0);
        step();
        chk("rst_j", 32'(j), 0);
        chk("rst_k", 32'(k), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_ready", 32'(cmd_ready), 0);
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("ready_after_rst", 32'(cmd_ready), 1);

        // Reset in the middle of a SET cnt=5
        push(2'b10, 4'd5);
        step();
        chk("mid_j", 32'(j), 1);
        chk("mid_busy", 32'(busy), 1);
        step();
        rst_n = 1'b0;
        #1;
        chk("async_rst_j", 32'(j), 0);
        chk("async_rst_k", 32'(k), 0);
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_err", 32'(err), 0);
        @(negedge clk) rst_n = 1'b1;
        step();
        chk("rerst_ready", 32'(cmd_ready), 1);
        chk("rerst_empty", 32'(busy), 0);
        step();
        chk("rerst_no_drive", 32'({j, k}), 0);

        // Single SET cnt=0 from q=0
        set_q(1'b0);
        push(2'b10, 4'd0);
        chk("set_idle_j", 32'(j), 0);
        step();
        chk("set_drive_jk", 32'({j, k}), 32'h2);
        chk("set_drive_done", 32'(done), 0);
        step();
        chk("set_check_done", 32'(done), 1);
        chk("set_check_jk", 32'({j, k}), 0);
        chk("set_check_q", 32'(q), 1);
        step();
        chk("set_done_pulse", 32'(done), 0);
        chk("set_err", 32'(err), 0);
        chk("set_busy_end", 32'(busy), 0);

        // TOGGLE cnt=2 from q=0, then TOGGLE cnt=1 from q=1
        set_q(1'b0);
        push(2'b11, 4'd2);
        wait_done(n);
        chk("tog3_len", 32'(n), 3);
        chk("tog3_q", 32'(q), 1);
        step();
        chk("tog3_err", 32'(err), 0);
        set_q(1'b1);
        push(2'b11, 4'd1);
        wait_done(n);
        chk("tog2_len", 32'(n), 2);
        chk("tog2_q", 32'(q), 1);
        step();
        chk("tog2_err", 32'(err), 0);

        // Back-pressure: long TOGGLE keeps the sequencer busy while 5 commands queue up
        base = log_q.size();
        push(2'b11, 4'd15);
        step();
        for (int c = 0; c < 4; c++) begin
            cmd_op = exp_log[c+1][7:6];
            cmd_cnt = 4'(exp_log[c+1][5:0] - 8'd1);
            cmd_valid = 1'b1;
            chk("bp_ready_before_full", 32'(cmd_ready), 1);
            step();
        end
        cmd_valid = 1'b0;
        chk("bp_full_after_4", 32'(cmd_ready), 0);
        cmd_op = 2'b01; cmd_cnt = 4'd1; cmd_valid = 1'b1;
        step();
        chk("bp_still_full", 32'(cmd_ready), 0);
        push(2'b01, 4'd1);
        for (int i = 0; i < 200; i++) begin
            if (log_q.size() >= base + 6) break;
            step();
        end
        chk("bp_all_done", 32'(log_q.size() - base), 6);
        for (int c = 0; c < 6; c++) begin
            if (log_q.size() > base + c) chk("bp_order", 32'(log_q[base+c]), 32'(exp_log[c]));
        end
        step();
        chk("bp_err", 32'(err), 0);

        // Stuck-at-0 q with SET: mismatch only when the checker is built in
        set_q(1'b0);
        stuck = 1'b1;
        push(2'b10, 4'd0);
        wait_done(n);
        step();
        chk("stuck_err", 32'(err), 32'(CHK));
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("err_clr", 32'(err), 0);
        push(2'b10, 4'd0);
        wait_done(n);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("set_beats_clr", 32'(err), 32'(CHK));
        stuck = 1'b0;
        step();
        chk("err_sticky", 32'(err), 32'(CHK));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
